fetch_stage: RTL and testbench

- IF stage of the 5-stage RISC-V core, directly upstream of the instruction memory and downstream into decode.
- Owns the PC register and drives PCF to the instruction memory address input.
- Captures the combinational instruction read (InstrF) into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect, and traps on illegal fetch addresses.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_if_id_reg.sv | 28 ++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: fetch FSM states, IF/ID bundle and fetch constants.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;

  // IF/ID pipeline bundle; the decode stage consumes the same layout.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // A fetch address is illegal when it is not word aligned or lies past the
  // end of instruction memory. limit is one bit wider so that an IMEM of
  // the full 4 GiB can still be expressed.
  function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                       input logic [XLEN:0]   limit);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats stall (hold) beats load.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble only replaces the instruction and clears valid; the PC fields
  // keep their last values so decode still sees a sensible PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{instr: BUBBLE_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    end else if (flush) begin
      q.instr <= BUBBLE_INSTR;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, fetch-fault trap
// and the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchFault,
  output logic [31:0] FaultPC
);

  import fetch_stage_pkg::*;

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e state, state_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        npc_fault;
  logic        pc_en;
  logic        fault_set;
  logic        ifid_flush;
  logic        ifid_stall;
  if_id_t      ifid_d;
  if_id_t      ifid_q;

  // One adder serves both the sequential next PC and PCPlus4D.
  assign pc_plus4 = PCF + 32'd4;

  // Next-PC select: a redirect overrides StallF, which overrides PC+4.
  always_comb begin
    npc = pc_plus4;
    if (PCSrcE) begin
      npc = PCTargetE;
    end else if (StallF) begin
      npc = PCF;
    end
  end

  assign npc_fault = fetch_fault(npc, IMEM_LIMIT);

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next state and control. BOOT and TRAP ignore hazard inputs
  // except that TRAP still honours StallD so decode can drain.
  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    fault_set  = 1'b0;
    ifid_flush = 1'b1;
    ifid_stall = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        ifid_flush = FlushD | PCSrcE;
        ifid_stall = StallD;
        if (npc_fault) begin
          state_nxt = TRAP;
          fault_set = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      TRAP: begin
        ifid_flush = ~StallD;
        ifid_stall = StallD;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // PC register; a faulting next PC is never loaded, so PCF keeps the last
  // legal address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (pc_en) begin
      PCF <= npc;
    end
  end

  // Sticky fault flag and address; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchFault <= 1'b0;
      FaultPC    <= '0;
    end else if (fault_set) begin
      FetchFault <= 1'b1;
      FaultPC    <= npc;
    end
  end

  assign ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4, valid: 1'b1};

  fetch_stage_if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(ifid_flush),
    .stall(ifid_stall),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchFault;
  logic [31:0] FaultPC;

  int checks;
  int errors;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(256),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PCF       (PCF),
    .InstrF    (InstrF),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchFault(FetchFault),
    .FaultPC   (FaultPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: words 0/1 fixed, word i otherwise is addi x0,x0,i.
  function automatic logic [31:0] imem_word(input int idx);
    if (idx == 0) return 32'hFFC4_A303;
    if (idx == 1) return 32'h0083_2383;
    return 32'h0000_0013 | (32'(idx) << 20);
  endfunction

  assign InstrF = (PCF < 32'h400) ? imem_word(int'(PCF[9:2])) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    tick();
    tick();

    // reset state
    check("rst_pcf", PCF, 32'h0);
    check("rst_instrd", InstrD, 32'h0000_0013);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcplus4d", PCPlus4D, 32'h0);
    check("rst_validd", {31'b0, ValidD}, 32'h0);
    check("rst_fault", {31'b0, FetchFault}, 32'h0);
    check("rst_faultpc", FaultPC, 32'h0);

    // release; first edge is the BOOT cycle
    rst_n = 1'b1;
    tick();
    check("boot_pcf", PCF, 32'h0);
    check("boot_validd", {31'b0, ValidD}, 32'h0);
    tick();
    check("run0_pcf", PCF, 32'h4);
    check("run0_instrd", InstrD, 32'hFFC4_A303);
    check("run0_pcd", PCD, 32'h0);
    check("run0_pcplus4d", PCPlus4D, 32'h4);
    check("run0_validd", {31'b0, ValidD}, 32'h1);
    tick();
    check("run1_pcf", PCF, 32'h8);
    check("run1_instrd", InstrD, 32'h0083_2383);
    check("run1_pcd", PCD, 32'h4);

    // stall both for three cycles at PCF=0x8
    StallF = 1'b1;
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pcf", PCF, 32'h8);
      check("stall_instrd", InstrD, 32'h0083_2383);
      check("stall_pcd", PCD, 32'h4);
      check("stall_pcplus4d", PCPlus4D, 32'h8);
      check("stall_validd", {31'b0, ValidD}, 32'h1);
    end
    StallF = 1'b0;
    StallD = 1'b0;
    tick();
    check("unstall_pcf", PCF, 32'hC);
    check("unstall_instrd", InstrD, 32'h0020_0013);
    check("unstall_pcd", PCD, 32'h8);

    // redirect overrides both stalls and bubbles IF/ID
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    StallF    = 1'b1;
    StallD    = 1'b1;
    tick();
    check("redir_pcf", PCF, 32'h40);
    check("redir_instrd", InstrD, 32'h0000_0013);
    check("redir_validd", {31'b0, ValidD}, 32'h0);
    check("redir_pcd_hold", PCD, 32'h8);
    PCSrcE = 1'b0;
    StallF = 1'b0;
    StallD = 1'b0;
    tick();
    check("redir_next_pcf", PCF, 32'h44);
    check("redir_next_instrd", InstrD, 32'h0100_0013);
    check("redir_next_pcd", PCD, 32'h40);

    // misaligned redirect traps
    PCSrcE    = 1'b1;
    PCTargetE = 32'h42;
    tick();
    check("trap_fault", {31'b0, FetchFault}, 32'h1);
    check("trap_faultpc", FaultPC, 32'h42);
    check("trap_pcf", PCF, 32'h44);
    check("trap_validd", {31'b0, ValidD}, 32'h0);
    PCTargetE = 32'h80;
    for (int i = 0; i < 5; i++) begin
      PCSrcE = i[0];
      StallF = i[1];
      tick();
      check("trap_hold_pcf", PCF, 32'h44);
      check("trap_hold_validd", {31'b0, ValidD}, 32'h0);
      check("trap_hold_faultpc", FaultPC, 32'h42);
    end
    PCSrcE = 1'b0;
    StallF = 1'b0;

    // reset out of trap, then run off the end of IMEM
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("boot2_pcf", PCF, 32'h0);
    check("boot2_fault", {31'b0, FetchFault}, 32'h0);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h3F8;
    tick();
    check("end_pcf0", PCF, 32'h3F8);
    PCSrcE = 1'b0;
    tick();
    check("end_pcf1", PCF, 32'h3FC);
    check("end_instrd1", InstrD, 32'h0FE0_0013);
    tick();
    check("end_fault", {31'b0, FetchFault}, 32'h1);
    check("end_faultpc", FaultPC, 32'h400);
    check("end_pcf2", PCF, 32'h3FC);
    check("end_instrd2", InstrD, 32'h0FF0_0013);
    check("end_pcd2", PCD, 32'h3FC);
    check("end_pcplus4d2", PCPlus4D, 32'h400);
    check("end_validd2", {31'b0, ValidD}, 32'h1);
    tick();
    check("end_trap_pcf", PCF, 32'h3FC);
    check("end_trap_validd", {31'b0, ValidD}, 32'h0);

    // asynchronous reset between edges clears the sticky fault at once
    rst_n = 1'b0;
    #2;
    check("arst1_pcf", PCF, 32'h0);
    check("arst1_fault", {31'b0, FetchFault}, 32'h0);
    check("arst1_faultpc", FaultPC, 32'h0);
    check("arst1_validd", {31'b0, ValidD}, 32'h0);
    check("arst1_instrd", InstrD, 32'h0000_0013);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("run2_pcf", PCF, 32'h10);
    check("run2_pcd", PCD, 32'hC);

    // flush bubbles IF/ID while the PC keeps advancing
    FlushD = 1'b1;
    tick();
    check("flush_pcf", PCF, 32'h14);
    check("flush_instrd", InstrD, 32'h0000_0013);
    check("flush_validd", {31'b0, ValidD}, 32'h0);
    check("flush_pcd_hold", PCD, 32'hC);
    FlushD = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("run3_pcf", PCF, 32'h20);
    check("run3_pcd", PCD, 32'h1C);
    check("run3_validd", {31'b0, ValidD}, 32'h1);

    // asynchronous reset mid-run at PCF=0x20
    rst_n = 1'b0;
    #2;
    check("arst2_pcf", PCF, 32'h0);
    check("arst2_validd", {31'b0, ValidD}, 32'h0);
    check("arst2_pcd", PCD, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
